// File: rtl/inst_prefetch.sv
// ---------------------------------------------------------------------------
// inst_prefetch
//
// Instruction fetch/prefetch stage of the Mercury core. It issues Wishbone
// classic single reads to the instruction ROM wrapper. Returned words are
// buffered with their PCs in a small FIFO, and the FIFO head is presented to
// the decode stage. A PC redirect flushes the FIFO. A read that is still in
// flight when the redirect arrives completes on the bus, and its data is
// thrown away.
//
// Optional feature macro: INST_PREFETCH_TIMEOUT_EN
//   defined   -> 8-bit ACK watchdog. On expiry the bus cycle is abandoned,
//                FETCH_ERR_OUT is set (sticky until reset), and fetching
//                stays halted until the next REDIRECT_IN.
//   undefined -> no watchdog. FETCH_ERR_OUT is tied low and the block waits
//                for ACK indefinitely.
//
// Parameters
//   RESET_VECTOR    first fetch byte address after reset (word-aligned)
//   FIFO_DEPTH      prefetch FIFO entries; power of two, 2..16
//   TIMEOUT_CYCLES  no-ACK cycles before the watchdog fires (1..256)
//
// Ports
//   CLK             clock, all logic on posedge
//   RST_SYNC        synchronous active-high reset
//   WB_CYC_OUT      Wishbone cycle
//   WB_STB_OUT      Wishbone strobe
//   WB_ADR_OUT      fetch byte address, bits [1:0] always 0
//   WB_ACK_IN       slave acknowledge
//   WB_DAT_RD_IN    slave read data, valid with WB_ACK_IN
//   INST_VALID_OUT  FIFO head holds a valid instruction
//   INST_DATA_OUT   instruction at FIFO head
//   INST_PC_OUT     byte address of INST_DATA_OUT
//   INST_READY_IN   decode pops the head when INST_VALID_OUT & INST_READY_IN
//   REDIRECT_IN     one-cycle pulse: flush and refetch
//   REDIRECT_PC_IN  new fetch address, bits [1:0] ignored
//   FETCH_ERR_OUT   sticky bus-timeout flag
// ---------------------------------------------------------------------------
module inst_prefetch #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_SYNC,
  output logic        WB_CYC_OUT,
  output logic        WB_STB_OUT,
  output logic [31:0] WB_ADR_OUT,
  input  logic        WB_ACK_IN,
  input  logic [31:0] WB_DAT_RD_IN,
  output logic        INST_VALID_OUT,
  output logic [31:0] INST_DATA_OUT,
  output logic [31:0] INST_PC_OUT,
  input  logic        INST_READY_IN,
  input  logic        REDIRECT_IN,
  input  logic [31:0] REDIRECT_PC_IN,
  output logic        FETCH_ERR_OUT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]        state_reg, state_next;
  // pc_reg is the address on the bus while a read is live. Otherwise it is
  // the next address to fetch.
  logic [31:0]       pc_reg, pc_next;
  // The redirect target is held here while the old read drains in DISCARD,
  // so that WB_ADR_OUT stays stable for the slave.
  logic [31:0]       pending_pc_reg, pending_pc_next;

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [31:0]       entry_pc_reg   [FIFO_DEPTH];
  logic [31:0]       entry_data_reg [FIFO_DEPTH];

  logic [31:0]       redirect_pc;
  logic              redirect_pc_unused;
  logic              fifo_valid;
  logic              pop;
  logic              push;
  logic              credit_idle;
  logic [CNT_W-1:0]  count_after_push;
  logic              credit_after_push;
  logic              timeout;
  logic              halted;

  assign redirect_pc        = {REDIRECT_PC_IN[31:2], 2'b00};
  assign redirect_pc_unused = ^REDIRECT_PC_IN[1:0];

  assign fifo_valid = (count_reg != '0);
  // When a pop and a flush happen in the same cycle, the flush wins.
  assign pop        = fifo_valid & INST_READY_IN & ~REDIRECT_IN;
  // An ACK in DISCARD, or an ACK in the same cycle as a redirect, is dropped.
  assign push       = (state_reg == ST_REQ) & WB_ACK_IN & ~REDIRECT_IN;

  // At most one read is outstanding. In IDLE nothing is outstanding, so the
  // credit test reduces to the occupancy alone.
  assign credit_idle       = (count_reg < DEPTH_CNT);
  assign count_after_push  = count_reg + CNT_W'(1) - CNT_W'(pop);
  assign credit_after_push = (count_after_push < DEPTH_CNT);

  // -------------------------------------------------------------------------
  // Optional ACK watchdog
  // -------------------------------------------------------------------------
`ifdef INST_PREFETCH_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wdog_reg;
  logic       err_reg;
  logic       halt_reg;

  // The watchdog fires in the TIMEOUT_CYCLES-th consecutive no-ACK cycle of
  // a live bus cycle.
  assign timeout = (state_reg != ST_IDLE) & ~WB_ACK_IN & (wdog_reg == WDOG_LAST);
  assign halted  = halt_reg;

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      wdog_reg <= 8'd0;
      err_reg  <= 1'b0;
      halt_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_IDLE) || WB_ACK_IN || timeout) begin
        wdog_reg <= 8'd0;
      end else begin
        wdog_reg <= wdog_reg + 8'd1;
      end
      err_reg  <= err_reg | timeout;
      // Only a redirect re-arms fetching after a timeout. A redirect in the
      // same cycle as the timeout re-arms it immediately.
      halt_reg <= (halt_reg | timeout) & ~REDIRECT_IN;
    end
  end

  assign FETCH_ERR_OUT = err_reg;
`else
  localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;

  assign timeout       = 1'b0;
  assign halted        = 1'b0;
  assign FETCH_ERR_OUT = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Fetch FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pending_pc_next = pending_pc_reg;
    case (state_reg)
      ST_IDLE: begin
        // A redirect seen in IDLE only loads the PC. The request starts in
        // the following cycle, once the flushed FIFO shows full credit.
        if (REDIRECT_IN) begin
          pc_next = redirect_pc;
        end else if (credit_idle && !halted) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (WB_ACK_IN) begin
          if (REDIRECT_IN) begin
            // The read has already ended, so there is nothing to drain. The
            // FIFO is flushed, so credit is guaranteed and the next request
            // can go straight out at the new PC.
            pc_next = redirect_pc;
          end else begin
            pc_next = pc_reg + 32'd4;
            if (!credit_after_push) begin
              state_next = ST_IDLE;
            end
          end
        end else if (timeout) begin
          state_next = ST_IDLE;
          if (REDIRECT_IN) begin
            pc_next = redirect_pc;
          end
        end else if (REDIRECT_IN) begin
          pending_pc_next = redirect_pc;
          state_next      = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (REDIRECT_IN) begin
          pending_pc_next = redirect_pc;
        end
        if (WB_ACK_IN || timeout) begin
          state_next = WB_ACK_IN ? ST_REQ : ST_IDLE;
          pc_next    = REDIRECT_IN ? redirect_pc : pending_pc_reg;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= RESET_VECTOR;
      pending_pc_reg <= RESET_VECTOR;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pending_pc_reg <= pending_pc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch FIFO
  // -------------------------------------------------------------------------
  // The pointers are exactly PTR_W bits wide and the depth is a power of two,
  // so they wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge CLK) begin
    if (RST_SYNC || REDIRECT_IN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // The entries are plain registers that are cleared on reset. This makes
  // the head outputs read zero out of reset. The head is driven only from
  // stored entries; returning bus data never bypasses straight to the
  // outputs.
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entry_pc_reg[i]   <= 32'd0;
        entry_data_reg[i] <= 32'd0;
      end
    end else if (push) begin
      entry_pc_reg[wr_ptr_reg]   <= pc_reg;
      entry_data_reg[wr_ptr_reg] <= WB_DAT_RD_IN;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // DISCARD keeps CYC/STB asserted because the slave still owes an ACK.
  assign WB_CYC_OUT     = (state_reg != ST_IDLE);
  assign WB_STB_OUT     = (state_reg != ST_IDLE);
  assign WB_ADR_OUT     = pc_reg;
  assign INST_VALID_OUT = fifo_valid;
  assign INST_DATA_OUT  = entry_data_reg[rd_ptr_reg];
  assign INST_PC_OUT    = entry_pc_reg[rd_ptr_reg];

endmodule

// File: tb/tb_inst_prefetch.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch
//
// Directed plus randomized bench for inst_prefetch. The slave returns data
// from a fixed address hash, using a registered ACK with a programmable wait.
// The reference model tracks the expected instruction stream as a queue of
// PCs. An ACK is accepted unless it belongs to a read that a redirect has
// made stale. A redirect empties the queue and restarts the expected PC.
// ---------------------------------------------------------------------------
module tb_inst_prefetch;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        RST_SYNC;
  logic        WB_CYC_OUT;
  logic        WB_STB_OUT;
  logic [31:0] WB_ADR_OUT;
  logic        WB_ACK_IN;
  logic [31:0] WB_DAT_RD_IN;
  logic        INST_VALID_OUT;
  logic [31:0] INST_DATA_OUT;
  logic [31:0] INST_PC_OUT;
  logic        INST_READY_IN;
  logic        REDIRECT_IN;
  logic [31:0] REDIRECT_PC_IN;
  logic        FETCH_ERR_OUT;

  always #5 clk = ~clk;

  inst_prefetch dut (
    .CLK            (clk),
    .RST_SYNC       (RST_SYNC),
    .WB_CYC_OUT     (WB_CYC_OUT),
    .WB_STB_OUT     (WB_STB_OUT),
    .WB_ADR_OUT     (WB_ADR_OUT),
    .WB_ACK_IN      (WB_ACK_IN),
    .WB_DAT_RD_IN   (WB_DAT_RD_IN),
    .INST_VALID_OUT (INST_VALID_OUT),
    .INST_DATA_OUT  (INST_DATA_OUT),
    .INST_PC_OUT    (INST_PC_OUT),
    .INST_READY_IN  (INST_READY_IN),
    .REDIRECT_IN    (REDIRECT_IN),
    .REDIRECT_PC_IN (REDIRECT_PC_IN),
    .FETCH_ERR_OUT  (FETCH_ERR_OUT)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model
  logic [31:0] model_q [$];
  logic [31:0] fetch_exp;
  logic        stale;
  int          ack_total;
  int          pop_total;
  logic [31:0] last_pop_pc;

  // slave model
  logic ack_prev;
  int   slv_cnt;
  int   slv_lat;
  int   lat_max;
  logic slv_mute;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, a[31:16] ^ 16'h9E01};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle. This task is entered at a negedge: it drives the inputs
  // for the coming posedge, checks the FIFO head against the model, updates
  // the model, and then waits for the next negedge.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rst);
    logic req_seen;
    logic outstanding;
    req_seen = WB_CYC_OUT && WB_STB_OUT;
    if (!req_seen || slv_mute) begin
      WB_ACK_IN = 1'b0;
      slv_cnt   = 0;
      slv_lat   = $urandom_range(1, lat_max);
    end else if (ack_prev) begin
      WB_ACK_IN = 1'b0;
      slv_cnt   = 1;
      slv_lat   = $urandom_range(1, lat_max);
    end else begin
      WB_ACK_IN = (slv_cnt >= slv_lat);
      slv_cnt   = WB_ACK_IN ? 0 : slv_cnt + 1;
    end
    WB_DAT_RD_IN   = WB_ACK_IN ? rom(WB_ADR_OUT) : $urandom;
    INST_READY_IN  = rdy;
    REDIRECT_IN    = redir;
    REDIRECT_PC_IN = rpc;
    RST_SYNC       = rst;

    chk("head_valid", 32'(INST_VALID_OUT), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      chk("head_pc", INST_PC_OUT, model_q[0]);
      chk("head_data", INST_DATA_OUT, rom(model_q[0]));
    end

    outstanding = req_seen && !WB_ACK_IN;
    if (rst) begin
      model_q.delete();
      fetch_exp = RV;
      stale     = 1'b0;
    end else begin
      if (model_q.size() != 0 && rdy && !redir) begin
        $display("pop pc=%h data=%h", INST_PC_OUT, INST_DATA_OUT);
        last_pop_pc = INST_PC_OUT;
        void'(model_q.pop_front());
        pop_total++;
      end
      if (WB_ACK_IN) begin
        if (stale || redir) begin
          stale = 1'b0;
        end else begin
          chk("ack_adr", WB_ADR_OUT, fetch_exp);
          model_q.push_back(fetch_exp);
          fetch_exp = fetch_exp + 32'd4;
          ack_total++;
        end
      end
      if (redir) begin
        model_q.delete();
        fetch_exp = {rpc[31:2], 2'b00};
        if (outstanding) stale = 1'b1;
      end
    end
    ack_prev = WB_ACK_IN;
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    $display("check reset outputs: %s", tag);
    chk({tag, "_cyc"}, 32'(WB_CYC_OUT), 32'd0);
    chk({tag, "_stb"}, 32'(WB_STB_OUT), 32'd0);
    chk({tag, "_adr"}, WB_ADR_OUT, RV);
    chk({tag, "_valid"}, 32'(INST_VALID_OUT), 32'd0);
    chk({tag, "_data"}, INST_DATA_OUT, 32'd0);
    chk({tag, "_pc"}, INST_PC_OUT, 32'd0);
    chk({tag, "_err"}, 32'(FETCH_ERR_OUT), 32'd0);
  endtask

  initial begin
    int n;
    int a0;
    int p0;
    RST_SYNC       = 1'b1;
    WB_ACK_IN      = 1'b0;
    WB_DAT_RD_IN   = 32'd0;
    INST_READY_IN  = 1'b0;
    REDIRECT_IN    = 1'b0;
    REDIRECT_PC_IN = 32'd0;
    fetch_exp      = RV;
    stale          = 1'b0;
    ack_total      = 0;
    pop_total      = 0;
    last_pop_pc    = 32'd0;
    ack_prev       = 1'b0;
    slv_cnt        = 0;
    slv_lat        = 1;
    lat_max        = 1;
    slv_mute       = 1'b0;
    @(negedge clk);

    // 1. Reset state.
    tick(0, 0, 32'd0, 1);
    tick(0, 0, 32'd0, 1);
    chk_reset_values("reset");

    // 2. The first request goes out right after reset is released.
    tick(1, 0, 32'd0, 0);
    $display("step: first request after reset");
    chk("first_cyc", 32'(WB_CYC_OUT), 32'd1);
    chk("first_stb", 32'(WB_STB_OUT), 32'd1);
    chk("first_adr", WB_ADR_OUT, RV);

    // 3. Streaming with a one-cycle ACK gives one word every two cycles.
    n = 0;
    while (ack_total < 1 && n < 50) begin tick(1, 0, 32'd0, 0); n++; end
    chk("wait_first_ack", 32'(n < 50), 32'd1);
    a0 = ack_total;
    repeat (20) tick(1, 0, 32'd0, 0);
    $display("step: throughput %0d words in 20 cycles", ack_total - a0);
    chk("throughput", 32'(ack_total - a0), 32'd10);

    // 4. The credit limit stops fetching when the FIFO is full.
    tick(0, 0, 32'd0, 1);
    tick(0, 0, 32'd0, 1);
    a0 = ack_total;
    repeat (40) tick(0, 0, 32'd0, 0);
    $display("step: stalled consumer, %0d requests", ack_total - a0);
    chk("credit_reqs", 32'(ack_total - a0), 32'd4);
    chk("credit_cyc_low", 32'(WB_CYC_OUT), 32'd0);
    a0 = ack_total;
    tick(1, 0, 32'd0, 0);
    repeat (20) tick(0, 0, 32'd0, 0);
    $display("step: single pop, %0d requests", ack_total - a0);
    chk("credit_one_more", 32'(ack_total - a0), 32'd1);
    chk("credit_cyc_low2", 32'(WB_CYC_OUT), 32'd0);

    // 5. A redirect while a read is in flight without ACK.
    n = 0;
    while (!(WB_CYC_OUT && (ack_prev || slv_cnt < slv_lat)) && n < 50) begin
      tick(1, 0, 32'd0, 0); n++;
    end
    chk("wait_req_noack", 32'(n < 50), 32'd1);
    tick(1, 1, 32'h0000_0100, 0);
    $display("step: redirect to 0x100 during REQ");
    chk("redir_flush_valid", 32'(INST_VALID_OUT), 32'd0);
    chk("redir_discard_cyc", 32'(WB_CYC_OUT), 32'd1);
    p0 = pop_total; n = 0;
    while (pop_total == p0 && n < 50) begin tick(1, 0, 32'd0, 0); n++; end
    chk("wait_pop_100", 32'(n < 50), 32'd1);
    chk("redir_first_pc", last_pop_pc, 32'h0000_0100);

    // 6. A redirect in the same cycle as an ACK.
    n = 0;
    while (!(WB_CYC_OUT && !ack_prev && slv_cnt >= slv_lat) && n < 50) begin
      tick(1, 0, 32'd0, 0); n++;
    end
    chk("wait_ack_cycle", 32'(n < 50), 32'd1);
    tick(1, 1, 32'h0000_0203, 0);
    $display("step: redirect to 0x203 with ACK");
    chk("redir_ack_adr", WB_ADR_OUT, 32'h0000_0200);
    chk("redir_ack_cyc", 32'(WB_CYC_OUT), 32'd1);
    p0 = pop_total; n = 0;
    while (pop_total == p0 && n < 50) begin tick(1, 0, 32'd0, 0); n++; end
    chk("wait_pop_200", 32'(n < 50), 32'd1);
    chk("redir_ack_first_pc", last_pop_pc, 32'h0000_0200);

    // 7. Reset during REQ with three entries buffered.
    n = 0;
    while (!(model_q.size() == 3 && WB_CYC_OUT) && n < 50) begin tick(0, 0, 32'd0, 0); n++; end
    chk("wait_three", 32'(n < 50), 32'd1);
    tick(0, 0, 32'd0, 1);
    chk_reset_values("midreset");
    tick(1, 0, 32'd0, 0);
    chk("refetch_cyc", 32'(WB_CYC_OUT), 32'd1);
    chk("refetch_adr", WB_ADR_OUT, RV);
    p0 = pop_total; n = 0;
    while (pop_total == p0 && n < 50) begin tick(1, 0, 32'd0, 0); n++; end
    chk("wait_pop_rv", 32'(n < 50), 32'd1);
    chk("refetch_first_pc", last_pop_pc, RV);

    // 8. Random traffic: variable ACK latency, stalls and redirects.
    $display("step: random traffic");
    lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
           $urandom & 32'h0000_FFFF, 1'b0);
    end
    chk("random_progress", 32'(pop_total > 100), 32'd1);

`ifdef INST_PREFETCH_TIMEOUT_EN
    // 9. The watchdog abandons a read that never gets an ACK.
    lat_max = 1;
    tick(0, 0, 32'd0, 1);
    tick(0, 0, 32'd0, 1);
    slv_mute = 1'b1;
    tick(0, 0, 32'd0, 0);
    n = 0;
    while (WB_CYC_OUT && n < 400) begin tick(0, 0, 32'd0, 0); n++; end
    $display("step: watchdog, bus held %0d cycles", n);
    chk("wdog_cycles", 32'(n), 32'd255);
    chk("wdog_err", 32'(FETCH_ERR_OUT), 32'd1);
    repeat (5) tick(0, 0, 32'd0, 0);
    chk("wdog_halted", 32'(WB_CYC_OUT), 32'd0);
    slv_mute = 1'b0;
    tick(1, 1, 32'h0000_0040, 0);
    n = 0;
    while (!WB_CYC_OUT && n < 10) begin tick(1, 0, 32'd0, 0); n++; end
    chk("wdog_resume", 32'(WB_CYC_OUT), 32'd1);
    chk("wdog_resume_adr", WB_ADR_OUT, 32'h0000_0040);
    chk("wdog_err_sticky", 32'(FETCH_ERR_OUT), 32'd1);
`else
    chk("err_tied_low", 32'(FETCH_ERR_OUT), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction fetch/prefetch stage of the Mercury core. It drives Wishbone classic read requests into the instruction ROM wrapper and buffers returned words in a small FIFO. It presents the words to the core decode stage with their PCs. It also handles PC redirects: it flushes the FIFO and discards any in-flight read.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset (word-aligned)
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, 2..16
- TIMEOUT_CYCLES, 255, ACK watchdog limit (used only with INST_PREFETCH_TIMEOUT_EN)

Ports (one clock, CLK; reset RST_SYNC is synchronous and active-high):
- CLK  in  1  clock; all logic on posedge
- RST_SYNC  in  1  synchronous active-high reset
- WB_CYC_OUT  out  1  Wishbone cycle
- WB_STB_OUT  out  1  Wishbone strobe
- WB_ADR_OUT  out  32  fetch byte address, bits [1:0] always 0
- WB_ACK_IN  in  1  slave acknowledge
- WB_DAT_RD_IN  in  32  slave read data, valid with WB_ACK_IN
- INST_VALID_OUT  out  1  FIFO head holds a valid instruction
- INST_DATA_OUT  out  32  instruction at FIFO head
- INST_PC_OUT  out  32  byte address of INST_DATA_OUT
- INST_READY_IN  in  1  core pops head when INST_VALID_OUT & INST_READY_IN
- REDIRECT_IN  in  1  one-cycle pulse: flush and refetch
- REDIRECT_PC_IN  in  32  new fetch address; bits [1:0] ignored
- FETCH_ERR_OUT  out  1  sticky bus-timeout flag

## Operation
- FSM states:
  - IDLE: no request on the bus.
  - REQ: WB_CYC_OUT/WB_STB_OUT high, awaiting ACK.
  - DISCARD: a request is in flight, but its data will be dropped.
- Fetch PC register: loads RESET_VECTOR on reset and REDIRECT_PC_IN & ~3 on redirect. It increments by 4 on each accepted ACK in REQ.
- Credit rule: a request is issued only if FIFO occupancy + outstanding < FIFO_DEPTH. At most one request is outstanding.
- IDLE -> REQ when credit is available and no redirect is pending.
- In REQ:
  - ACK with no REDIRECT_IN: push {PC, data} into the FIFO. Go to REQ with PC+4 if credit remains, else IDLE.
  - REDIRECT_IN without ACK: go to DISCARD.
- In DISCARD: on ACK, drop the data and go to REQ at the redirect PC.
- Redirect handling:
  - Every redirect clears the FIFO in the same cycle; INST_VALID_OUT is 0 in the next cycle.
  - A pop in the same cycle as a redirect is ignored; the flush wins.
  - REDIRECT_IN on the same cycle as an ACK: the data is dropped, no DISCARD is needed, and the next request uses the redirect PC.
  - REDIRECT_IN while in DISCARD: update the pending PC and stay in DISCARD.
- WB_ACK_IN is ignored in IDLE.
- Push and pop in the same cycle are legal at any occupancy. Occupancy is unchanged and the FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: WB_CYC_OUT=0, WB_STB_OUT=0, WB_ADR_OUT=RESET_VECTOR, INST_VALID_OUT=0, INST_DATA_OUT=0, INST_PC_OUT=0, FETCH_ERR_OUT=0, FIFO empty, state IDLE.
- A reset asserted mid-transfer drops CYC/STB the next cycle and does not wait for ACK.
- First request: CYC/STB are high in the first cycle after RST_SYNC deasserts.
- STB stays high across back-to-back requests. WB_ADR_OUT advances in the cycle after each ACK.
- With the ROM wrapper's one-cycle ACK, throughput is one word per 2 cycles.
- Latency: INST_VALID_OUT rises in the cycle after the ACK. The FIFO output is registered and there is no bypass.
- Redirect to first new ACK: at least 2 cycles, or 1 extra ACK cycle if in DISCARD.

## Configuration
- INST_PREFETCH_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in REQ/DISCARD without ACK.
  - When it reaches TIMEOUT_CYCLES: drop CYC/STB, set FETCH_ERR_OUT (sticky until reset), and go to IDLE.
  - Fetching resumes only after REDIRECT_IN.
- Undefined: no watchdog; FETCH_ERR_OUT is tied to 0 and the block waits for ACK indefinitely.

## Test plan
- Reset release, slave ACKs 1 cycle after STB, INST_READY_IN=1 -> ADR sequence BFC0_0000, BFC0_0004, BFC0_0008; INST_PC_OUT matches each word; one word per 2 cycles.
- INST_READY_IN=0, FIFO_DEPTH=4 -> exactly 4 requests, then CYC/STB low. Raise READY for 1 cycle -> exactly one new request.
- REDIRECT_IN to 0x0000_0100 while in REQ with no ACK -> FIFO empty next cycle. Next ACK's data is discarded, then ADR=0x100; the first INST_PC_OUT is 0x100.
- REDIRECT_IN in the same cycle as an ACK, with REDIRECT_PC_IN=0x0000_0203 -> data dropped; next ADR=0x200 with no DISCARD cycle.
- Assert RST_SYNC during REQ with 3 FIFO entries -> next cycle all outputs at reset values; refetch starts at RESET_VECTOR.
- With INST_PREFETCH_TIMEOUT_EN, hold ACK low -> after 255 cycles CYC/STB drop and FETCH_ERR_OUT=1. A redirect resumes fetching while FETCH_ERR_OUT stays 1.
